branch_predictor: RTL and testbench

- Parametrised branch target buffer with per-entry saturating direction counters for the IF stage of the pipelined CPU.
- Replaces the fixed "predict not taken, flush on resolve" policy.
- IF looks up the current PC combinationally and gets a predicted next PC.
- ID/EX reports resolved branches back through an update port.
- Keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_predictor.sv | 110 +++++++++++
 tb/tb_branch_predictor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters for IF-stage next-PC prediction.
// Lookup is combinational. Resolved branches train the table on the clock edge.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  input  logic              clear_i,
  output logic [STAT_W-1:0] stat_branch_o,
  output logic [STAT_W-1:0] stat_mispred_o
);

  localparam int IW    = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IW - 2;
  localparam logic [CNT_W-1:0] WT      = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] WNT     = WT - CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  logic [IW-1:0]    lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IW-1:0]    up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [CNT_W-1:0] cnt_nxt;
  logic             mispred;
  logic             unused_pc_lsbs;

  // Instructions are word aligned, so the byte offset never reaches the table.
  assign unused_pc_lsbs = ^{pc_i[1:0], upd_pc_i[1:0]};

  assign lk_idx = pc_i[IW+1:2];
  assign lk_tag = pc_i[ADDR_W-1:IW+2];
  assign up_idx = upd_pc_i[IW+1:2];
  assign up_tag = upd_pc_i[ADDR_W-1:IW+2];

  assign pred_hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = pred_hit_o && cnt_q[lk_idx][CNT_W-1];
  assign pred_target_o = pred_taken_o ? target_q[lk_idx] : pc_i + ADDR_W'(4);

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    cnt_nxt = cnt_q[up_idx];
    if (upd_taken_i) begin
      if (cnt_q[up_idx] != CNT_MAX) cnt_nxt = cnt_q[up_idx] + CNT_W'(1);
    end else begin
      if (cnt_q[up_idx] != '0) cnt_nxt = cnt_q[up_idx] - CNT_W'(1);
    end
  end

  assign mispred = (upd_taken_i != upd_pred_taken_i) ||
                   (upd_taken_i && upd_pred_taken_i && (upd_target_i != upd_pred_target_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= WNT;
      end
    end else if (clear_i) begin
      // Clear wins over a same-cycle training write; tags and targets are left stale.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= WNT;
      end
    end else if (upd_valid_i) begin
      if (up_hit) begin
        cnt_q[up_idx] <= cnt_nxt;
        if (upd_taken_i) target_q[up_idx] <= upd_target_i;
      end else if (upd_taken_i) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target_i;
        cnt_q[up_idx]    <= WT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_branch_o  <= '0;
      stat_mispred_o <= '0;
    end else if (upd_valid_i) begin
      if (stat_branch_o != STAT_MAX) stat_branch_o <= stat_branch_o + STAT_W'(1);
      if (mispred && (stat_mispred_o != STAT_MAX)) stat_mispred_o <= stat_mispred_o + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a vector table for the lookup/train sequence,
// then hand-written sequences for async reset, X tolerance and statistics saturation.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;
  logic        clear_i;
  logic [3:0]  stat_branch_o;
  logic [3:0]  stat_mispred_o;

  int checks   = 0;
  int failures = 0;

  branch_predictor #(.ENTRIES(16), .ADDR_W(32), .CNT_W(2), .STAT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i), .clear_i(clear_i),
    .stat_branch_o(stat_branch_o), .stat_mispred_o(stat_mispred_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        clr;
    logic [31:0] pc;
    logic        e_hit;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic [3:0]  e_br;
    logic [3:0]  e_mp;
  } vec_t;

  vec_t vecs [30];

  function automatic vec_t mk(logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt, logic clr,
                              logic [31:0] pc, logic e_hit, logic e_taken, logic [31:0] e_tgt,
                              logic [3:0] e_br, logic [3:0] e_mp);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.clr = clr; v.pc = pc;
    v.e_hit = e_hit; v.e_taken = e_taken; v.e_tgt = e_tgt; v.e_br = e_br; v.e_mp = e_mp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic hit, input logic taken,
                           input logic [31:0] tgt, input logic [3:0] br, input logic [3:0] mp);
    check({tag, " hit"},     {31'b0, pred_hit_o},     {31'b0, hit});
    check({tag, " taken"},   {31'b0, pred_taken_o},   {31'b0, taken});
    check({tag, " target"},  pred_target_o,           tgt);
    check({tag, " branch"},  {28'b0, stat_branch_o},  {28'b0, br});
    check({tag, " mispred"}, {28'b0, stat_mispred_o}, {28'b0, mp});
  endtask

  task automatic idle_inputs();
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;
    upd_pred_taken_i = 1'b0; upd_pred_target_i = '0; clear_i = 1'b0;
  endtask

  // One training update whose carried prediction is supplied explicitly.
  task automatic train(input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic upt, input logic [31:0] uptgt);
    @(posedge clk_i); #1;
    upd_valid_i = 1'b1; upd_pc_i = upc; upd_taken_i = ut; upd_target_i = utgt;
    upd_pred_taken_i = upt; upd_pred_target_i = uptgt; clear_i = 1'b0;
  endtask

  initial begin
    // 0x40, 0x440, 0x840 and 0x80 all map to index 0 with different tags.
    vecs[0]  = mk(0, 32'h0,   0, 32'h0,   0, 32'h40,  0, 0, 32'h44,  0,  0);
    vecs[1]  = mk(1, 32'h40,  1, 32'h100, 0, 32'h40,  0, 0, 32'h44,  0,  0);
    vecs[2]  = mk(0, 32'h0,   0, 32'h0,   0, 32'h40,  1, 1, 32'h100, 1,  0);
    vecs[3]  = mk(1, 32'h40,  0, 32'h3c0, 0, 32'h40,  1, 1, 32'h100, 1,  0);
    vecs[4]  = mk(1, 32'h40,  0, 32'h3c0, 0, 32'h40,  1, 0, 32'h44,  2,  0);
    vecs[5]  = mk(1, 32'h40,  0, 32'h3c0, 0, 32'h40,  1, 0, 32'h44,  3,  0);
    vecs[6]  = mk(1, 32'h40,  1, 32'h100, 0, 32'h40,  1, 0, 32'h44,  4,  0);
    vecs[7]  = mk(1, 32'h40,  1, 32'h100, 0, 32'h40,  1, 0, 32'h44,  5,  0);
    vecs[8]  = mk(1, 32'h40,  1, 32'h100, 0, 32'h40,  1, 1, 32'h100, 6,  0);
    vecs[9]  = mk(1, 32'h40,  1, 32'h100, 0, 32'h40,  1, 1, 32'h100, 7,  0);
    vecs[10] = mk(1, 32'h40,  0, 32'h3c0, 0, 32'h40,  1, 1, 32'h100, 8,  0);
    vecs[11] = mk(0, 32'h0,   0, 32'h0,   0, 32'h40,  1, 1, 32'h100, 9,  0);
    vecs[12] = mk(1, 32'h40,  1, 32'h180, 0, 32'h40,  1, 1, 32'h100, 9,  0);
    vecs[13] = mk(0, 32'h0,   0, 32'h0,   0, 32'h40,  1, 1, 32'h180, 10, 0);
    vecs[14] = mk(0, 32'h0,   0, 32'h0,   0, 32'h440, 0, 0, 32'h444, 10, 0);
    vecs[15] = mk(1, 32'h440, 1, 32'h200, 0, 32'h440, 0, 0, 32'h444, 10, 0);
    vecs[16] = mk(0, 32'h0,   0, 32'h0,   0, 32'h440, 1, 1, 32'h200, 11, 0);
    vecs[17] = mk(0, 32'h0,   0, 32'h0,   0, 32'h40,  0, 0, 32'h44,  11, 0);
    vecs[18] = mk(1, 32'h840, 0, 32'h300, 0, 32'h840, 0, 0, 32'h844, 11, 0);
    vecs[19] = mk(0, 32'h0,   0, 32'h0,   0, 32'h440, 1, 1, 32'h200, 12, 0);
    vecs[20] = mk(1, 32'h80,  1, 32'h500, 1, 32'h440, 1, 1, 32'h200, 12, 0);
    vecs[21] = mk(0, 32'h0,   0, 32'h0,   0, 32'h80,  0, 0, 32'h84,  13, 0);
    vecs[22] = mk(0, 32'h0,   0, 32'h0,   0, 32'h440, 0, 0, 32'h444, 13, 0);
    vecs[23] = mk(1, 32'h80,  1, 32'h500, 0, 32'h80,  0, 0, 32'h84,  13, 0);
    vecs[24] = mk(0, 32'h0,   0, 32'h0,   0, 32'h80,  1, 1, 32'h500, 14, 0);
    vecs[25] = mk(0, 32'h0,   0, 32'h0,   0, 32'hfffffffc, 0, 0, 32'h0, 14, 0);
    vecs[26] = mk(0, 32'h0,   0, 32'h0,   0, 32'h83,  1, 1, 32'h500, 14, 0);
    vecs[27] = mk(1, 32'h80,  1, 32'h500, 0, 32'h80,  1, 1, 32'h500, 14, 0);
    vecs[28] = mk(1, 32'h80,  1, 32'h500, 0, 32'h80,  1, 1, 32'h500, 15, 0);
    vecs[29] = mk(0, 32'h0,   0, 32'h0,   0, 32'h80,  1, 1, 32'h500, 15, 0);

    rst_i = 1'b0;
    pc_i  = 32'h40;
    idle_inputs();
    #22;
    rst_i = 1'b1;

    // Each row: drive, check the pre-update lookup, then let the edge apply the update.
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_i); #1;
      upd_valid_i = vecs[i].uv; upd_pc_i = vecs[i].upc; upd_taken_i = vecs[i].ut;
      upd_target_i = vecs[i].utgt; upd_pred_taken_i = vecs[i].ut;
      upd_pred_target_i = vecs[i].utgt; clear_i = vecs[i].clr; pc_i = vecs[i].pc;
      #3;
      check_all($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_taken, vecs[i].e_tgt,
                vecs[i].e_br, vecs[i].e_mp);
    end

    // X on the update bus with valid low must not touch table or stats.
    @(posedge clk_i); #1;
    upd_valid_i = 1'b0; upd_pc_i = 'x; upd_taken_i = 1'bx; upd_target_i = 'x;
    upd_pred_taken_i = 1'bx; upd_pred_target_i = 'x; pc_i = 32'h80;
    @(posedge clk_i); #1;
    idle_inputs();
    #3;
    check_all("xidle", 1'b1, 1'b1, 32'h500, 4'd15, 4'd0);

    // Asynchronous reset mid-cycle, with an update in flight.
    @(posedge clk_i); #2;
    upd_valid_i = 1'b1; upd_pc_i = 32'h80; upd_taken_i = 1'b1; upd_target_i = 32'h600;
    upd_pred_taken_i = 1'b0; upd_pred_target_i = 32'h84;
    rst_i = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 32'h84, 4'd0, 4'd0);
    repeat (2) @(posedge clk_i);
    #1;
    check_all("rst_hold", 1'b0, 1'b0, 32'h84, 4'd0, 4'd0);
    idle_inputs();
    #2;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    pc_i = 32'h40;
    #3;
    check_all("post_rst", 1'b0, 1'b0, 32'h44, 4'd0, 4'd0);

    // Mispredict accounting from a clean reset.
    train(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    @(posedge clk_i); #1; idle_inputs(); #3;
    check({"mp dir"}, {28'b0, stat_mispred_o}, 32'd1);
    train(32'h40, 1'b1, 32'h100, 1'b1, 32'h104);
    @(posedge clk_i); #1; idle_inputs(); #3;
    check({"mp target"}, {28'b0, stat_mispred_o}, 32'd2);
    train(32'h40, 1'b0, 32'h100, 1'b0, 32'h104);
    @(posedge clk_i); #1; idle_inputs(); #3;
    check({"mp nt diff tgt"}, {28'b0, stat_mispred_o}, 32'd2);
    check({"mp br3"}, {28'b0, stat_branch_o}, 32'd3);
    for (int k = 0; k < 20; k++) train(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    @(posedge clk_i); #1; idle_inputs(); #3;
    check({"mp sat"}, {28'b0, stat_mispred_o}, 32'd15);
    check({"br sat"}, {28'b0, stat_branch_o}, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
